// File: rtl/ahb_nametable_dma_master_pkg.sv
// ---------------------------------------------------------------------------
// ahb_nametable_dma_master_pkg
// Shared definitions for the nametable DMA master: FSM state encoding,
// AHB-lite transfer-control constants and an address alignment helper.
// No ports; imported by the interface users and the DMA master.
// ---------------------------------------------------------------------------
package ahb_nametable_dma_master_pkg;

    // Job sequencer states. RD_A/WR_A are AHB address phases, RD_D/WR_D the
    // matching data phases, FIN the single-cycle completion state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // AHB-lite HTRANS encodings used by this master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Every transfer is a single 32-bit, non-cacheable privileged data access
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // Address step between consecutive words
    localparam logic [31:0] WORD_BYTES   = 32'd4;

    // Word-align a byte address by clearing bits [1:0]
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ahb_nametable_dma_master_if.sv
// ---------------------------------------------------------------------------
// ahb_nametable_dma_master_if
// AHB-lite bus bundle between the nametable DMA master and its slave.
//   master modport: drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA,
//                   receives HREADY/HRDATA/HRESP
//   slave modport : the reverse direction of every signal
// Clock and reset are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface ahb_nametable_dma_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;

    modport master (
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HBURST,
        output HPROT,
        output HWDATA,
        input  HREADY,
        input  HRDATA,
        input  HRESP
    );

    modport slave (
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HBURST,
        input  HPROT,
        input  HWDATA,
        output HREADY,
        output HRDATA,
        output HRESP
    );

endinterface

// File: rtl/ahb_nametable_dma_master.sv
// ---------------------------------------------------------------------------
// ahb_nametable_dma_master
// Single-channel AHB-lite DMA master that either copies len words from
// src_addr to dst_addr (read then write, one word at a time) or fills len
// words at dst_addr with a constant word.
//
// Ports
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   start         : one-cycle job request, honoured only when idle
//   fill_mode     : 1 = fill with fill_data, 0 = copy from src_addr
//   src_addr      : source byte address (copy mode)
//   dst_addr      : destination byte address
//   fill_data     : fill word (fill mode)
//   len           : number of 32-bit words to transfer
//   busy          : high while a job is in progress
//   done          : one-cycle pulse when a job finishes or aborts
//   error         : sticky, set when the last job was aborted by HRESP
//   ahb           : AHB-lite master bus bundle
//
// All outputs are registered: each is computed from the next state and
// loaded on the same edge as the state register.
// ---------------------------------------------------------------------------
module ahb_nametable_dma_master
    import ahb_nametable_dma_master_pkg::*;
#(
    parameter int LEN_WIDTH = 11
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic                 fill_mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [31:0]          fill_data,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    ahb_nametable_dma_master_if.master ahb
);

    // Sequencer and job context
    state_t                 state_reg, state_next;
    logic [31:0]            src_reg, src_next;        // address of next word to read
    logic [31:0]            dst_reg, dst_next;        // address of next word to write
    logic [LEN_WIDTH-1:0]   cnt_reg, cnt_next;        // words still to write
    logic [31:0]            data_reg, data_next;      // last word read
    logic [31:0]            fill_data_reg, fill_data_next;
    logic                   fill_mode_reg, fill_mode_next;

    // Registered outputs
    logic [31:0]            haddr_reg, haddr_next;
    logic [31:0]            hwdata_reg, hwdata_next;
    logic [1:0]             htrans_reg, htrans_next;
    logic                   hwrite_reg, hwrite_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   error_reg, error_next;

    // Only HRESP[0] (ERROR) matters to this master
    logic                   unused_hresp;
    assign unused_hresp = ahb.HRESP[1];

    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        cnt_next       = cnt_reg;
        data_next      = data_reg;
        fill_data_next = fill_data_reg;
        fill_mode_next = fill_mode_reg;
        haddr_next     = haddr_reg;
        hwdata_next    = hwdata_reg;
        error_next     = error_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // Latch the whole job; the request inputs are free to
                    // change from the next cycle on.
                    src_next       = word_align(src_addr);
                    dst_next       = word_align(dst_addr);
                    cnt_next       = len;
                    fill_data_next = fill_data;
                    fill_mode_next = fill_mode;
                    error_next     = 1'b0;
                    if (len == '0) begin
                        state_next = ST_FIN;
                    end else if (fill_mode) begin
                        state_next = ST_WR_A;
                        haddr_next = word_align(dst_addr);
                    end else begin
                        state_next = ST_RD_A;
                        haddr_next = word_align(src_addr);
                    end
                end
            end

            ST_RD_A: begin
                if (ahb.HREADY) begin
                    state_next = ST_RD_D;
                end
            end

            ST_RD_D: begin
                // An ERROR response aborts immediately; the second cycle of
                // the two-cycle AHB error response is not waited for.
                if (ahb.HRESP[0]) begin
                    state_next = ST_FIN;
                    error_next = 1'b1;
                end else if (ahb.HREADY) begin
                    data_next  = ahb.HRDATA;
                    src_next   = src_reg + WORD_BYTES;
                    state_next = ST_WR_A;
                    haddr_next = dst_reg;
                end
            end

            ST_WR_A: begin
                if (ahb.HREADY) begin
                    state_next  = ST_WR_D;
                    // Loaded once on entry so the write data stays stable
                    // through any data-phase wait states.
                    hwdata_next = fill_mode_reg ? fill_data_reg : data_reg;
                end
            end

            ST_WR_D: begin
                if (ahb.HRESP[0]) begin
                    state_next = ST_FIN;
                    error_next = 1'b1;
                end else if (ahb.HREADY) begin
                    dst_next = dst_reg + WORD_BYTES;
                    cnt_next = cnt_reg - LEN_WIDTH'(1);
                    if (cnt_reg == LEN_WIDTH'(1)) begin
                        state_next = ST_FIN;
                    end else if (fill_mode_reg) begin
                        state_next = ST_WR_A;
                        haddr_next = dst_reg + WORD_BYTES;
                    end else begin
                        state_next = ST_RD_A;
                        haddr_next = src_reg;
                    end
                end
            end

            ST_FIN: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Bus control and status follow the state being entered, so they
        // line up with state_reg on the next cycle.
        htrans_next = ((state_next == ST_RD_A) || (state_next == ST_WR_A))
                      ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite_next = (state_next == ST_WR_A);
        busy_next   = (state_next != ST_IDLE);
        done_next   = (state_next == ST_FIN);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= ST_IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            cnt_reg       <= '0;
            data_reg      <= '0;
            fill_data_reg <= '0;
            fill_mode_reg <= 1'b0;
            haddr_reg     <= '0;
            hwdata_reg    <= '0;
            htrans_reg    <= HTRANS_IDLE;
            hwrite_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            cnt_reg       <= cnt_next;
            data_reg      <= data_next;
            fill_data_reg <= fill_data_next;
            fill_mode_reg <= fill_mode_next;
            haddr_reg     <= haddr_next;
            hwdata_reg    <= hwdata_next;
            htrans_reg    <= htrans_next;
            hwrite_reg    <= hwrite_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
        end
    end

    assign ahb.HADDR  = haddr_reg;
    assign ahb.HTRANS = htrans_reg;
    assign ahb.HWRITE = hwrite_reg;
    assign ahb.HWDATA = hwdata_reg;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HBURST = HBURST_SINGLE;
    assign ahb.HPROT  = HPROT_DATA;

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign error = error_reg;

endmodule

// File: tb/tb_ahb_nametable_dma_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_nametable_dma_master
// Self-checking bench: a behavioural AHB slave (memory + wait/error
// injection) answers the DMA master, records completed writes, and each
// scenario task compares them with a job-level reference model.
// ---------------------------------------------------------------------------
module tb_ahb_nametable_dma_master;

    localparam int LW = 11;

    logic          HCLK;
    logic          HRESETn;
    logic          start;
    logic          fill_mode;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [31:0]   fill_data;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          error;

    ahb_nametable_dma_master_if ahb();

    ahb_nametable_dma_master #(.LEN_WIDTH(LW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .fill_mode (fill_mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .fill_data (fill_data),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .ahb       (ahb)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int passes = 0;

    // ---------------- slave environment state ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    int  rd_a_waits = 0;        // wait cycles for the next read address phase
    int  wr_d_waits = 0;        // wait cycles for the next write data phase
    int  err_on_read = 0;       // 1-based read index answered with ERROR (0 = none)
    int  read_index = 0;        // completed reads in the current job
    int  waits_injected = 0;
    int  addr_phases = 0;       // accepted NONSEQ address phases
    int  stable_violations = 0;
    bit  rand_waits = 0;

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: list of (address, data) writes a job must produce
    function automatic void model_job(input bit fm, input logic [31:0] s,
                                      input logic [31:0] d, input logic [31:0] f,
                                      input int n);
        logic [31:0] sa;
        logic [31:0] da;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < n; i++) begin
            sa = (s & 32'hFFFF_FFFC) + 32'(4 * i);
            da = (d & 32'hFFFF_FFFC) + 32'(4 * i);
            exp_addr_q.push_back(da);
            exp_data_q.push_back(fm ? f : slave_word(sa));
        end
    endfunction

    function automatic int model_cycles(input bit fm, input int n, input int waits);
        if (n == 0) return 1;
        return 1 + n * (fm ? 2 : 4) + waits;
    endfunction

    // ---------------- behavioural AHB slave ----------------
    initial begin : slave_model
        bit in_data, in_write, is_addr, hr, err;
        bit prev_addr_wait, prev_data_wait, prev_hwrite;
        logic [31:0] prev_haddr, prev_hwdata;
        bit dphase_valid, dphase_write;
        logic [31:0] dphase_addr;
        prev_addr_wait = 0; prev_data_wait = 0; prev_hwrite = 0;
        prev_haddr = '0; prev_hwdata = '0;
        dphase_valid = 0; dphase_write = 0; dphase_addr = '0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 2'b00;
        ahb.HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dphase_valid = 0; prev_addr_wait = 0; prev_data_wait = 0;
                ahb.HREADY = 1'b1; ahb.HRESP = 2'b00;
                continue;
            end
            // Outputs must hold while the slave stalls
            if (prev_addr_wait && (ahb.HTRANS !== 2'b10 || ahb.HADDR !== prev_haddr ||
                                   ahb.HWRITE !== prev_hwrite))
                stable_violations++;
            if (prev_data_wait && ahb.HWDATA !== prev_hwdata)
                stable_violations++;

            in_data  = dphase_valid;
            in_write = dphase_write;
            is_addr  = (ahb.HTRANS === 2'b10);
            hr = 1; err = 0;
            if (in_data && !in_write && err_on_read != 0 && read_index + 1 == err_on_read) begin
                err = 1; hr = 0;
            end else if (in_data && in_write && wr_d_waits > 0) begin
                hr = 0; wr_d_waits--;
            end else if (is_addr && !ahb.HWRITE && !in_data && rd_a_waits > 0) begin
                hr = 0; rd_a_waits--;
            end else if (rand_waits && (is_addr || in_data) && $urandom_range(0, 3) == 0) begin
                hr = 0;
            end
            if (!hr && !err) waits_injected++;

            ahb.HREADY = hr;
            ahb.HRESP  = err ? 2'b01 : 2'b00;
            ahb.HRDATA = (in_data && !in_write && hr) ? slave_word(dphase_addr) : $urandom;

            // Effect of the coming clock edge
            if (err) begin
                dphase_valid = 0;
                err_on_read  = 0;
            end else if (hr) begin
                if (in_data) begin
                    if (in_write) begin
                        wr_addr_q.push_back(dphase_addr);
                        wr_data_q.push_back(ahb.HWDATA);
                    end else begin
                        read_index++;
                    end
                end
                if (is_addr) begin
                    dphase_valid = 1;
                    dphase_write = ahb.HWRITE;
                    dphase_addr  = ahb.HADDR;
                    addr_phases++;
                end else begin
                    dphase_valid = 0;
                end
            end
            prev_addr_wait = is_addr && !hr;
            prev_haddr     = ahb.HADDR;
            prev_hwrite    = ahb.HWRITE;
            prev_data_wait = in_data && in_write && !hr && !err;
            prev_hwdata    = ahb.HWDATA;
        end
    end

    // Issue one job and measure the cycle (relative to the start cycle) on
    // which done is seen. cyc = -1 if done never arrives.
    task automatic run_job(input bit fm, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] f, input int n, input int intrude,
                           output int cyc, output bit busy_ok,
                           output logic done_after, output logic busy_after);
        @(negedge HCLK);
        wr_addr_q.delete(); wr_data_q.delete();
        addr_phases = 0; read_index = 0; waits_injected = 0;
        start = 1'b1; fill_mode = fm; src_addr = s; dst_addr = d;
        fill_data = f; len = LW'(n);
        cyc = -1; busy_ok = 1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge HCLK);
            start     = (c == intrude);
            fill_mode = 1'($urandom_range(0, 1));
            src_addr  = $urandom;
            dst_addr  = $urandom;
            fill_data = $urandom;
            len       = LW'($urandom_range(1, 7));
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
        end
        start = 1'b0;
        @(negedge HCLK);
        done_after = done;
        busy_after = busy;
        $display("job fill=%0d src=%h dst=%h data=%h len=%0d done_cycle=%0d writes=%0d error=%0d",
                 fm, s, d, f, n, cyc, wr_addr_q.size(), error);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        HRESETn = 1'b0; start = 1'b0; fill_mode = 1'b0;
        src_addr = '0; dst_addr = '0; fill_data = '0; len = '0;
        repeat (3) @(negedge HCLK);
        checks++;
        if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags: busy/done/error=%b expected 000", {busy, done, error});
        else passes++;
        checks++;
        if ({ahb.HTRANS, ahb.HWRITE} !== 3'b000) $display("FAIL reset_htrans_hwrite: got %b expected 000", {ahb.HTRANS, ahb.HWRITE});
        else passes++;
        checks++;
        if (ahb.HADDR !== 32'h0 || ahb.HWDATA !== 32'h0) $display("FAIL reset_haddr_hwdata: got %h/%h expected 0/0", ahb.HADDR, ahb.HWDATA);
        else passes++;
        checks++;
        if ({ahb.HSIZE, ahb.HBURST, ahb.HPROT} !== 10'b010_000_0011) $display("FAIL const_ctrl: hsize/hburst/hprot=%b expected 0100000011", {ahb.HSIZE, ahb.HBURST, ahb.HPROT});
        else passes++;
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_copy();
        int cyc; bit bok; logic da, ba;
        mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
        model_job(0, 32'h100, 32'h4000, 32'h0, 3);
        run_job(0, 32'h100, 32'h4000, 32'hDEAD_BEEF, 3, 0, cyc, bok, da, ba);
        checks++;
        if (cyc !== model_cycles(0, 3, 0)) $display("FAIL copy_done_cycle: got %0d expected %0d", cyc, model_cycles(0, 3, 0));
        else passes++;
        checks++;
        if (!bok || da !== 1'b0 || ba !== 1'b0) $display("FAIL copy_busy_done: busy_ok=%0d done_after=%b busy_after=%b expected 1 0 0", bok, da, ba);
        else passes++;
        checks++;
        if (addr_phases !== 6 || error !== 1'b0) $display("FAIL copy_bus: addr_phases=%0d error=%b expected 6 0", addr_phases, error);
        else passes++;
        checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL copy_write_count: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
        else passes++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                $display("FAIL copy_write[%0d]: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            else passes++;
        end
    endtask

    task automatic test_fill();
        int cyc; bit bok; logic da, ba;
        model_job(1, 32'h0, 32'h4000, 32'h55, 4);
        run_job(1, 32'h1234, 32'h4000, 32'h55, 4, 0, cyc, bok, da, ba);
        checks++;
        if (cyc !== model_cycles(1, 4, 0)) $display("FAIL fill_done_cycle: got %0d expected %0d", cyc, model_cycles(1, 4, 0));
        else passes++;
        checks++;
        if (!bok || da !== 1'b0 || addr_phases !== 4) $display("FAIL fill_bus: busy_ok=%0d done_after=%b addr_phases=%0d expected 1 0 4", bok, da, addr_phases);
        else passes++;
        checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL fill_write_count: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
        else passes++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                $display("FAIL fill_write[%0d]: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            else passes++;
        end
    endtask

    task automatic test_wait_states();
        int cyc; bit bok; logic da, ba;
        stable_violations = 0;
        rd_a_waits = 2; wr_d_waits = 2;
        model_job(0, 32'h200, 32'h5000, 32'h0, 2);
        run_job(0, 32'h200, 32'h5000, 32'h0, 2, 0, cyc, bok, da, ba);
        checks++;
        if (cyc !== model_cycles(0, 2, 0) + 4) $display("FAIL wait_done_cycle: got %0d expected %0d", cyc, model_cycles(0, 2, 0) + 4);
        else passes++;
        checks++;
        if (waits_injected !== 4 || stable_violations !== 0) $display("FAIL wait_stability: waits=%0d violations=%0d expected 4 0", waits_injected, stable_violations);
        else passes++;
        checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL wait_write_count: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
        else passes++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                $display("FAIL wait_write[%0d]: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            else passes++;
        end
    endtask

    task automatic test_error_zero_len();
        int cyc; bit bok; logic da, ba;
        err_on_read = 2;
        model_job(0, 32'h300, 32'h6000, 32'h0, 1);   // only the first word lands
        run_job(0, 32'h300, 32'h6000, 32'h0, 4, 0, cyc, bok, da, ba);
        // word 1 takes cycles 1-4, read 2 errors in its data phase (cycle 6)
        checks++;
        if (cyc !== 7) $display("FAIL error_done_cycle: got %0d expected 7", cyc);
        else passes++;
        checks++;
        if (addr_phases !== 3 || wr_addr_q.size() !== 1) $display("FAIL error_bus: addr_phases=%0d writes=%0d expected 3 1", addr_phases, wr_addr_q.size());
        else passes++;
        checks++;
        if (wr_addr_q.size() > 0 && (wr_addr_q[0] !== exp_addr_q[0] || wr_data_q[0] !== exp_data_q[0]))
            $display("FAIL error_first_write: got %h@%h expected %h@%h", wr_data_q[0], wr_addr_q[0], exp_data_q[0], exp_addr_q[0]);
        else passes++;
        repeat (3) @(negedge HCLK);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) $display("FAIL error_sticky: error=%b busy=%b expected 1 0", error, busy);
        else passes++;
        run_job(0, 32'h300, 32'h6000, 32'h0, 0, 0, cyc, bok, da, ba);
        checks++;
        if (cyc !== model_cycles(0, 0, 0)) $display("FAIL zero_len_done_cycle: got %0d expected %0d", cyc, model_cycles(0, 0, 0));
        else passes++;
        checks++;
        if (error !== 1'b0 || addr_phases !== 0 || wr_addr_q.size() !== 0) $display("FAIL zero_len_bus: error=%b addr_phases=%0d writes=%0d expected 0 0 0", error, addr_phases, wr_addr_q.size());
        else passes++;
    endtask

    task automatic test_start_ignored();
        int cyc; bit bok; logic da, ba;
        model_job(1, 32'h0, 32'h8000, 32'h11, 2);
        run_job(1, 32'h0, 32'h8000, 32'h11, 2, 2, cyc, bok, da, ba);
        checks++;
        if (cyc !== model_cycles(1, 2, 0) || addr_phases !== 2) $display("FAIL busy_start_ignored: done_cycle=%0d addr_phases=%0d expected %0d 2", cyc, addr_phases, model_cycles(1, 2, 0));
        else passes++;
        checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL busy_write_count: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
        else passes++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                $display("FAIL busy_write[%0d]: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        int cyc; bit bok; logic da, ba;
        model_job(1, 32'h0, 32'hFFFF_FFFC, 32'h77, 2);
        run_job(1, 32'h0, 32'hFFFF_FFFC, 32'h77, 2, 0, cyc, bok, da, ba);
        checks++;
        if (wr_addr_q.size() !== 2) $display("FAIL wrap_fill_count: got %0d expected 2", wr_addr_q.size());
        else passes++;
        if (wr_addr_q.size() == 2) begin
            checks++;
            if (wr_addr_q[1] !== 32'h0000_0000 || wr_data_q[1] !== 32'h77) $display("FAIL wrap_fill_second: got %h@%h expected 00000077@00000000", wr_data_q[1], wr_addr_q[1]);
            else passes++;
        end
        // Unaligned, wrapping source and destination in copy mode
        model_job(0, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0, 3);
        run_job(0, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0, 3, 0, cyc, bok, da, ba);
        checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL wrap_copy_count: got %0d expected %0d", wr_addr_q.size(), exp_addr_q.size());
        else passes++;
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                $display("FAIL wrap_copy_write[%0d]: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_midjob();
        @(negedge HCLK);
        start = 1'b1; fill_mode = 1'b1; dst_addr = 32'h4000; fill_data = 32'h55; len = LW'(4);
        @(negedge HCLK);
        start = 1'b0;
        @(negedge HCLK);   // cycle 2: first write data phase
        checks++;
        if (ahb.HADDR !== 32'h4000 || ahb.HWDATA !== 32'h55 || busy !== 1'b1) $display("FAIL midjob_wr_d: haddr=%h hwdata=%h busy=%b expected 00004000 00000055 1", ahb.HADDR, ahb.HWDATA, busy);
        else passes++;
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, ahb.HTRANS, ahb.HWRITE} !== 6'b0 || ahb.HADDR !== 32'h0 || ahb.HWDATA !== 32'h0)
            $display("FAIL async_reset: busy/done/error/htrans/hwrite=%b haddr=%h hwdata=%h expected all 0", {busy, done, error, ahb.HTRANS, ahb.HWRITE}, ahb.HADDR, ahb.HWDATA);
        else passes++;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge HCLK);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || ahb.HTRANS !== 2'b00) $display("FAIL post_reset_idle[%0d]: busy=%b done=%b htrans=%b expected 0 0 00", c, busy, done, ahb.HTRANS);
            else passes++;
        end
    endtask

    task automatic test_random();
        int cyc; bit bok; logic da, ba;
        bit fm; int n; logic [31:0] s, d, f;
        rand_waits = 1;
        for (int j = 0; j < 16; j++) begin
            fm = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 6);
            s  = $urandom; d = $urandom; f = $urandom;
            model_job(fm, s, d, f, n);
            run_job(fm, s, d, f, n, 0, cyc, bok, da, ba);
            checks++;
            if (cyc !== model_cycles(fm, n, waits_injected) || error !== 1'b0)
                $display("FAIL rand_job[%0d]: done_cycle=%0d error=%b expected %0d 0", j, cyc, error, model_cycles(fm, n, waits_injected));
            else passes++;
            checks++;
            if (wr_addr_q.size() !== exp_addr_q.size()) $display("FAIL rand_write_count[%0d]: got %0d expected %0d", j, wr_addr_q.size(), exp_addr_q.size());
            else passes++;
            for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
                checks++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])
                    $display("FAIL rand_write[%0d][%0d]: got %h@%h expected %h@%h", j, i, wr_data_q[i], wr_addr_q[i], exp_data_q[i], exp_addr_q[i]);
                else passes++;
            end
        end
        rand_waits = 0;
    endtask

    initial begin
        test_reset();
        test_copy();
        test_fill();
        test_wait_states();
        test_error_zero_len();
        test_start_ignored();
        test_wrap();
        test_reset_midjob();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
